// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver: double-buffered BCD digits,
// leading-zero blanking, per-digit decimal points and per-digit blinking.
module seg_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 83
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] i_digits,
  input  logic [5:0]  i_dp,
  input  logic        i_load,
  input  logic [5:0]  i_blink_mask,
  input  logic        i_blank_lz,
  output logic [6:0]  o_seg,
  output logic        o_seg_dp,
  output logic [5:0]  o_seg_enb,
  output logic        o_frame
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [2:0]    IDX_LAST   = 3'd5;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][3:0] shadow_dig_q, shadow_dig_d;
  logic [5:0]      shadow_dp_q, shadow_dp_d;
  logic [5:0][3:0] act_dig_q, act_dig_d;
  logic [5:0]      act_dp_q, act_dp_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_ph_q, blink_ph_d;
  logic [6:0]      seg_q, seg_d;
  logic            seg_dp_q, seg_dp_d;
  logic [5:0]      seg_enb_q, seg_enb_d;
  logic            frame_q, frame_d;

  logic            slot_tick_s;
  logic            boundary_s;
  logic [5:0]      lz_zero_s;
  logic [3:0]      cur_dig_s;
  logic            blank_s;
  logic            dark_s;

  assign slot_tick_s = (presc_q == PRESC_LAST);
  assign boundary_s  = slot_tick_s && (idx_q == IDX_LAST);

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (slot_tick_s) begin
      presc_d = '0;
      if (boundary_s) begin
        idx_d = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // A load coinciding with the frame boundary bypasses the shadow so it is not a frame late.
  always_comb begin
    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    act_dig_d    = act_dig_q;
    act_dp_d     = act_dp_q;
    if (i_load) begin
      shadow_dig_d = i_digits;
      shadow_dp_d  = i_dp;
    end else begin
      shadow_dig_d = shadow_dig_q;
      shadow_dp_d  = shadow_dp_q;
    end
    if (boundary_s) begin
      if (i_load) begin
        act_dig_d = i_digits;
        act_dp_d  = i_dp;
      end else begin
        act_dig_d = shadow_dig_q;
        act_dp_d  = shadow_dp_q;
      end
    end else begin
      act_dig_d = act_dig_q;
      act_dp_d  = act_dp_q;
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (boundary_s) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
  end

  // lz_zero_s[n]: digit n and every digit above it are zero.
  always_comb begin
    lz_zero_s    = 6'b000000;
    lz_zero_s[5] = (act_dig_q[5] == 4'd0);
    for (int n = 4; n >= 0; n--) begin
      lz_zero_s[n] = lz_zero_s[n+1] && (act_dig_q[n] == 4'd0);
    end
  end

  always_comb begin
    cur_dig_s = act_dig_q[idx_q];
    blank_s   = i_blank_lz && (idx_q != 3'd0) && lz_zero_s[idx_q];
    dark_s    = blink_ph_q && i_blink_mask[idx_q];
    seg_d     = bcd_to_seg(cur_dig_s);
    seg_dp_d  = act_dp_q[idx_q];
    if (dark_s) begin
      seg_d    = 7'h00;
      seg_dp_d = 1'b0;
    end else if (blank_s) begin
      seg_d    = 7'h00;
    end else begin
      seg_d    = bcd_to_seg(cur_dig_s);
    end
    seg_enb_d = ~(6'b000001 << idx_q);
    frame_d   = boundary_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= 3'd0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= 6'b000000;
      act_dig_q    <= '0;
      act_dp_q     <= 6'b000000;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      seg_q        <= 7'h00;
      seg_dp_q     <= 1'b0;
      seg_enb_q    <= 6'b111111;
      frame_q      <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      seg_enb_q    <= seg_enb_d;
      frame_q      <= frame_d;
    end
  end

  assign o_seg     = seg_q;
  assign o_seg_dp  = seg_dp_q;
  assign o_seg_enb = seg_enb_q;
  assign o_frame   = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: stimulus queues per-slot expectations,
// a negedge monitor pops them as each digit slot appears on the enables.
module tb_seg_scan_driver;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_CYC    = 6 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] i_digits = 24'h000000;
  logic [5:0]  i_dp = 6'b000000;
  logic        i_load = 1'b0;
  logic [5:0]  i_blink_mask = 6'b000000;
  logic        i_blank_lz = 1'b0;
  logic [6:0]  o_seg;
  logic        o_seg_dp;
  logic [5:0]  o_seg_enb;
  logic        o_frame;

  seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk(clk), .rst(rst), .i_digits(i_digits), .i_dp(i_dp), .i_load(i_load),
    .i_blink_mask(i_blink_mask), .i_blank_lz(i_blank_lz),
    .o_seg(o_seg), .o_seg_dp(o_seg_dp), .o_seg_enb(o_seg_enb), .o_frame(o_frame)
  );

  always #5 clk = ~clk;

  typedef struct { int frame; int digit; logic [6:0] seg; logic dp; } exp_t;
  exp_t exp_q[$];

  int   checks = 0;
  int   failures = 0;
  int   mon_frame = 0;
  int   since = 0;
  bit   have_frame = 1'b0;
  bit   post_rst = 1'b0;
  logic [5:0] prev_enb = 6'b111111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_frame(input int f, input logic [5:0][6:0] segs, input logic [5:0] dps,
                            input int first_d);
    exp_t e;
    for (int i = first_d; i < 6; i++) begin
      e.frame = f; e.digit = i; e.seg = segs[i]; e.dp = dps[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_load(input logic [23:0] d, input logic [5:0] dp);
    i_digits = d; i_dp = dp; i_load = 1'b1;
    @(posedge clk); #1;
    i_load = 1'b0;
  endtask

  // Returns just after the negedge of the first cycle of a new frame.
  task automatic wait_frame();
    int n = 0;
    @(negedge clk);
    while (!o_frame && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_frame) begin
      checks++; failures++;
      $display("FAIL wait_frame: got no o_frame pulse expected one within 200 cycles");
    end
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain: got %0d pending slots expected 0", exp_q.size());
    end
  endtask

  always @(posedge clk) post_rst = !rst;

  always @(negedge clk) begin
    int d;
    exp_t e;
    if (rst) begin
      mon_frame = 0; prev_enb = 6'b111111; have_frame = 1'b0; since = 0;
    end else if (post_rst) begin
      check("enb_one_cold", $countones(~o_seg_enb), 1);
      since++;
      if (o_frame) begin
        mon_frame++;
        if (have_frame) check("frame_period", since, FRAME_CYC);
        have_frame = 1'b1;
        since = 0;
      end
      if (o_seg_enb != prev_enb) begin
        d = 0;
        for (int i = 0; i < 6; i++) if (!o_seg_enb[i]) d = i;
        while (exp_q.size() > 0 && (exp_q[0].frame < mon_frame ||
               (exp_q[0].frame == mon_frame && exp_q[0].digit < d))) begin
          e = exp_q.pop_front();
          checks++; failures++;
          $display("FAIL slot_missed f%0d d%0d: got no slot expected one", e.frame, e.digit);
        end
        if (exp_q.size() > 0 && exp_q[0].frame == mon_frame && exp_q[0].digit == d) begin
          e = exp_q.pop_front();
          check($sformatf("seg_f%0d_d%0d", e.frame, d), o_seg, e.seg);
          check($sformatf("dp_f%0d_d%0d", e.frame, d), o_seg_dp, e.dp);
        end
        prev_enb = o_seg_enb;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0][6:0] s;
    int n;

    // Reset values, first slots after release, asynchronous mid-scan reset.
    repeat (3) @(posedge clk); #1;
    check("rst_enb", o_seg_enb, 6'b111111);
    check("rst_seg", o_seg, 7'h00);
    check("rst_frame", o_frame, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("enb_first", o_seg_enb, 6'b111110);
    check("seg_first", o_seg, 7'h3F);
    repeat (3) @(posedge clk); #1;
    check("enb_slot0_end", o_seg_enb, 6'b111110);
    @(posedge clk); #1;
    check("enb_slot1", o_seg_enb, 6'b111101);
    n = 0;
    while (o_seg_enb != 6'b110111 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("reach_digit3", o_seg_enb, 6'b110111);
    #2 rst = 1'b1;
    #1;
    check("async_rst_enb", o_seg_enb, 6'b111111);
    check("async_rst_seg", o_seg, 7'h00);
    check("async_rst_dp", o_seg_dp, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("enb_after_rerst", o_seg_enb, 6'b111110);

    // Mid-frame loads: current frame keeps zeros, last load wins next frame.
    wait_frame();
    push_frame(mon_frame, {6{7'h3F}}, 6'b000000, 1);
    push_frame(mon_frame + 1, {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}, 6'b100001, 0);
    repeat (4) @(posedge clk); #1;
    pulse_load(24'h999999, 6'b111111);
    repeat (5) @(posedge clk); #1;
    pulse_load(24'h123456, 6'b100001);

    // Load on the boundary cycle itself goes straight to the next frame.
    wait_frame();
    push_frame(mon_frame + 1, {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66}, 6'b000000, 0);
    repeat (23) @(posedge clk); #1;
    pulse_load(24'h987654, 6'b000000);

    // Leading-zero blanking and dash decode.
    i_blank_lz = 1'b1;
    wait_frame();
    push_frame(mon_frame + 1, {7'h00, 7'h00, 7'h06, 7'h3F, 7'h3F, 7'h3F}, 6'b010000, 0);
    repeat (8) @(posedge clk); #1;
    pulse_load(24'h001000, 6'b010000);
    wait_frame();
    push_frame(mon_frame + 1, {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}, 6'b000000, 0);
    repeat (8) @(posedge clk); #1;
    pulse_load(24'h000000, 6'b000000);
    wait_frame();
    push_frame(mon_frame + 1, {7'h00, 7'h00, 7'h00, 7'h40, 7'h3F, 7'h3F}, 6'b000000, 0);
    repeat (8) @(posedge clk); #1;
    pulse_load(24'h000B00, 6'b000000);
    wait_frame();
    push_frame(mon_frame + 1, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F}, 6'b000000, 0);
    repeat (8) @(posedge clk); #1;
    pulse_load(24'hFEDCA0, 6'b000000);
    wait_drain();

    // Blinking from a fresh reset: digits 0,1 dark in frames 2-3.
    @(posedge clk); #1;
    rst = 1'b1;
    i_blank_lz = 1'b0;
    i_blink_mask = 6'b000011;
    i_digits = 24'h000000;
    i_dp = 6'b000000;
    for (int f = 0; f < 6; f++) begin
      s = {6{7'h3F}};
      if (f == 2 || f == 3) begin
        s[0] = 7'h00;
        s[1] = 7'h00;
      end
      push_frame(f, s, (f >= 1) ? 6'b000100 : 6'b000000, 0);
    end
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    pulse_load(24'h000000, 6'b000100);
    wait_drain();

    // Random traffic; the monitor keeps checking one-cold enables and frame period.
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      i_load = ($urandom_range(0, 3) == 0);
      i_digits = 24'($urandom);
      i_dp = 6'($urandom);
      i_blink_mask = 6'($urandom);
      i_blank_lz = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    i_load = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
